// File: rtl/moggysoc_uart_pkg.sv
// Shared definitions for the UART transmit peripheral: register map,
// STATUS bit positions, transmitter state encoding and divisor floor.
package moggysoc_uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 8;

    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // A bit time shorter than two cycles cannot be counted reliably.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/moggy_sync_fifo.sv
// Single-clock FIFO with show-ahead output; a push on a full FIFO only
// lands when a pop frees a slot in the same cycle.
module moggy_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: register window, TX FIFO and an 8N1
// serialiser running at a programmable cycles-per-bit divisor.
module uart_tx_periph
    import moggysoc_uart_pkg::*;
#(
    parameter logic [30:0] BASE_ADDR  = 31'h0000_1000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd542
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        bus_valid,
    input  logic [30:0] bus_addr,
    input  logic        bus_write,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wstrb,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        uart_tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    off;
    logic          sel, wr, push, pop, busy;
    logic          fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [15:0]   div_q, div_new;
    logic          ctrl_en, irq_en, ovf;
    logic [31:0]   status_w, rdata_nxt;
    logic          unused;

    tx_state_t   state;
    logic [15:0] div_lat, cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        tx_q, bit_end;

    assign unused = ^{bus_addr[1:0], bus_wdata[31:16], bus_wstrb[3:2]};

    // No new access is taken while our own ready pulse is on the bus.
    assign sel  = bus_valid && (bus_addr[30:4] == BASE_ADDR[30:4]) && !bus_ready;
    assign wr   = sel && bus_write;
    assign off  = bus_addr[3:2];
    assign push = wr && (off == REG_TXDATA) && bus_wstrb[0];
    assign pop  = (state == TX_IDLE) && ctrl_en && !fifo_empty;
    assign busy = (state != TX_IDLE);
    assign irq  = irq_en && fifo_empty && !busy;
    assign uart_tx = tx_q;

    moggy_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (bus_wdata[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        div_new = div_q;
        if (bus_wstrb[0]) div_new[7:0]  = bus_wdata[7:0];
        if (bus_wstrb[1]) div_new[15:8] = bus_wdata[15:8];
    end

    always_comb begin
        status_w                     = '0;
        status_w[ST_BUSY]            = busy;
        status_w[ST_FULL]            = fifo_full;
        status_w[ST_EMPTY]           = fifo_empty;
        status_w[ST_OVF]             = ovf;
        status_w[ST_CNT_LSB +: 8]    = 8'(fifo_count);
    end

    always_comb begin
        rdata_nxt = '0;
        case (off)
            REG_STATUS: rdata_nxt = status_w;
            REG_DIV:    rdata_nxt = {16'h0, div_q};
            REG_CTRL:   rdata_nxt = {30'h0, irq_en, ctrl_en};
            default:    rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= DIV_RESET;
            ctrl_en   <= 1'b0;
            irq_en    <= 1'b0;
            ovf       <= 1'b0;
            bus_ready <= 1'b0;
            bus_rdata <= '0;
        end else begin
            bus_ready <= sel;
            bus_rdata <= (sel && !bus_write) ? rdata_nxt : '0;
            if (push && fifo_full && !pop)
                ovf <= 1'b1;
            else if (wr && off == REG_STATUS && bus_wstrb[0] && bus_wdata[ST_OVF])
                ovf <= 1'b0;
            if (wr && off == REG_DIV)
                div_q <= clamp_div(div_new);
            if (wr && off == REG_CTRL && bus_wstrb[0]) begin
                ctrl_en <= bus_wdata[0];
                irq_en  <= bus_wdata[1];
            end
        end
    end

    assign bit_end = (cnt == div_lat - 16'd1);

    // Divisor is sampled at the pop so a mid-frame DIV write waits a frame.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            tx_q    <= 1'b1;
            div_lat <= DIV_MIN;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (pop) begin
                        state   <= TX_START;
                        tx_q    <= 1'b0;
                        div_lat <= div_q;
                        cnt     <= '0;
                        shreg   <= fifo_dout;
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx_q    <= shreg[0];
                        state   <= TX_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= TX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_q    <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        state <= TX_IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph: register access, frame shape, FIFO
// overflow, back-to-back frames, irq and reset in the middle of a frame.
module tb_uart_tx_periph;

    localparam logic [30:0] BASE = 31'h0000_1000;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_valid = 1'b0;
    logic [30:0] bus_addr = '0;
    logic        bus_write = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic [3:0]  bus_wstrb = '0;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        uart_tx;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_periph dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_write (bus_write),
        .bus_wdata (bus_wdata),
        .bus_wstrb (bus_wstrb),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .uart_tx   (uart_tx),
        .irq       (irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s);
        @(posedge sys_clk); #1;
        bus_valid = 1'b1; bus_write = 1'b1;
        bus_addr  = BASE + 31'(off); bus_wdata = d; bus_wstrb = s;
        @(posedge sys_clk); #1;
        bus_valid = 1'b0; bus_write = 1'b0; bus_wstrb = '0;
    endtask

    task automatic bus_rd(input logic [30:0] addr, output logic rdy, output logic [31:0] d);
        @(posedge sys_clk); #1;
        bus_valid = 1'b1; bus_write = 1'b0; bus_addr = addr;
        @(posedge sys_clk); #1;
        bus_valid = 1'b0;
        rdy = bus_ready;
        d   = bus_rdata;
    endtask

    task automatic wait_start(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge sys_clk); #1;
            if (uart_tx == 1'b0) found = 1'b1;
        end
        chk(tag, {31'h0, found}, 32'h1);
    endtask

    // Entered on the first sample of the start bit; leaves on the last stop-bit sample.
    task automatic check_frame(input logic [7:0] b, input int div, input string tag);
        logic [9:0] fr;
        logic       obs;
        fr = {1'b1, b, 1'b0};
        for (int bi = 0; bi < 10; bi++) begin
            obs = fr[bi];
            for (int k = 0; k < div; k++) begin
                if (bi != 0 || k != 0) begin
                    @(posedge sys_clk); #1;
                end
                if (uart_tx !== fr[bi]) obs = uart_tx;
            end
            chk($sformatf("%s_bit%0d", tag, bi), {31'h0, obs}, {31'h0, fr[bi]});
        end
    endtask

    initial begin
        logic        rdy;
        logic [31:0] d;
        logic        got;
        int          gap;
        logic        line_bad;

        // reset values
        #23;
        chk("rst_tx", {31'h0, uart_tx}, 32'h1);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_ready", {31'h0, bus_ready}, 32'h0);
        chk("rst_rdata", bus_rdata, 32'h0);
        @(posedge sys_clk); #1;
        rst_n = 1'b1;

        bus_rd(BASE + 31'h8, rdy, d);
        chk("div_rst_ready", {31'h0, rdy}, 32'h1);
        chk("div_rst", d, 32'd542);
        bus_rd(BASE + 31'h4, rdy, d);
        chk("status_rst", d, 32'h0000_0004);
        chk("idle_tx", {31'h0, uart_tx}, 32'h1);
        chk("idle_irq", {31'h0, irq}, 32'h0);

        // single 0xA5 frame at 4 cycles per bit
        bus_wr(4'h8, 32'd4, 4'h3);
        bus_wr(4'hC, 32'h1, 4'h1);
        bus_wr(4'h0, 32'hA5, 4'h1);
        wait_start("a5_start");
        check_frame(8'hA5, 4, "a5");
        @(posedge sys_clk); #1;
        chk("a5_after", {31'h0, uart_tx}, 32'h1);
        bus_rd(BASE + 31'h4, rdy, d);
        chk("a5_status", d, 32'h0000_0004);

        // overflow with transmitter disabled
        bus_wr(4'hC, 32'h0, 4'h1);
        for (int i = 0; i < 9; i++) bus_wr(4'h0, 32'(i + 16), 4'h1);
        bus_rd(BASE + 31'h4, rdy, d);
        chk("ovf_status", d, 32'h0000_080A);
        bus_wr(4'h4, 32'h8, 4'h1);
        bus_rd(BASE + 31'h4, rdy, d);
        chk("ovf_clear", d, 32'h0000_0802);

        // drain the eight queued bytes
        bus_wr(4'h8, 32'd2, 4'h3);
        bus_wr(4'hC, 32'h1, 4'h1);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            bus_rd(BASE + 31'h4, rdy, d);
            if (d == 32'h0000_0004) got = 1'b1;
        end
        chk("drain_done", {31'h0, got}, 32'h1);

        // back-to-back frames and irq
        bus_wr(4'hC, 32'h2, 4'h1);
        chk("irq_empty_idle", {31'h0, irq}, 32'h1);
        bus_wr(4'h0, 32'h01, 4'h1);
        bus_wr(4'h0, 32'h02, 4'h1);
        chk("irq_not_empty", {31'h0, irq}, 32'h0);
        bus_wr(4'hC, 32'h3, 4'h1);
        wait_start("b2b_start");
        check_frame(8'h01, 2, "f01");
        got = 1'b0;
        gap = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(posedge sys_clk); #1;
            if (uart_tx == 1'b0) got = 1'b1;
            else gap++;
        end
        chk("b2b_gap_le1", {31'h0, (got && gap <= 1)}, 32'h1);
        check_frame(8'h02, 2, "f02");
        chk("irq_in_stop", {31'h0, irq}, 32'h0);
        @(posedge sys_clk); #1;
        chk("irq_after_stop", {31'h0, irq}, 32'h1);

        // divisor clamp and address decode
        bus_wr(4'h8, 32'd1, 4'h3);
        bus_rd(BASE + 31'h8, rdy, d);
        chk("div_clamp", d, 32'd2);
        bus_rd(BASE + 31'h10, rdy, d);
        chk("unsel_ready", {31'h0, rdy}, 32'h0);
        chk("unsel_rdata", d, 32'h0);

        // reset in the middle of DATA bit 3
        bus_wr(4'hC, 32'h0, 4'h1);
        bus_wr(4'h8, 32'd4, 4'h3);
        bus_wr(4'h0, 32'h52, 4'h1);
        bus_wr(4'h0, 32'h33, 4'h1);
        bus_wr(4'hC, 32'h1, 4'h1);
        wait_start("mid_start");
        bus_rd(BASE + 31'h4, rdy, d);
        chk("mid_status", d, 32'h0000_0101);
        repeat (15) begin
            @(posedge sys_clk); #1;
        end
        chk("mid_bit3", {31'h0, uart_tx}, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", {31'h0, uart_tx}, 32'h1);
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        repeat (2) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        bus_rd(BASE + 31'h4, rdy, d);
        chk("post_rst_status", d, 32'h0000_0004);
        line_bad = 1'b0;
        repeat (60) begin
            @(posedge sys_clk); #1;
            if (uart_tx !== 1'b1) line_bad = 1'b1;
        end
        chk("post_rst_line_idle", {31'h0, line_bad}, 32'h0);
        bus_rd(BASE + 31'h8, rdy, d);
        chk("post_rst_div", d, 32'd542);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
